// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  // funct3 encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    CAUSE_MISALIGNED = 2'd0,
    CAUSE_RANGE      = 2'd1,
    CAUSE_TIMEOUT    = 2'd2,
    CAUSE_ILLEGAL    = 2'd3
  } cause_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_e;

  // Access size implied by the low two funct3 bits (11 is never legal).
  function automatic size_e f3_size(input logic [1:0] f3_lo);
    case (f3_lo)
      2'b00:   return SIZE_B;
      2'b01:   return SIZE_H;
      default: return SIZE_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational address/data shaping for the load/store unit: effective
// address, fault classification, store data masking and load extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_base,
  input  logic [31:0]       req_imm,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        ld_funct3,
  input  logic [31:0]       ld_data,
  output logic [ADDR_W-1:0] word_addr,
  output logic [1:0]        byte_off,
  output logic              fault,
  output logic [1:0]        cause,
  output logic [1:0]        size,
  output logic [31:0]       st_data,
  output logic [31:0]       ld_ext
);

  logic [31:0] ea;
  logic        illegal;
  logic        misaligned;
  logic        out_of_range;

  // Classify the request; faults are reported in priority order illegal, misaligned, range.
  always_comb begin
    ea         = req_base + req_imm;
    word_addr  = ea[ADDR_W+1:2];
    byte_off   = ea[1:0];
    size       = f3_size(req_funct3[1:0]);

    if (req_we) illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    else        illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);

    case (req_funct3[1:0])
      2'b01:   misaligned = ea[0];
      2'b10:   misaligned = (ea[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase

    out_of_range = |ea[31:ADDR_W+2];
    fault        = illegal || misaligned || out_of_range;

    if (illegal)         cause = CAUSE_ILLEGAL;
    else if (misaligned) cause = CAUSE_MISALIGNED;
    else                 cause = CAUSE_RANGE;
  end

  // Right-justify store data and clear the bytes beyond the access size.
  always_comb begin
    case (req_funct3[1:0])
      2'b00:   st_data = {24'b0, req_wdata[7:0]};
      2'b01:   st_data = {16'b0, req_wdata[15:0]};
      default: st_data = req_wdata;
    endcase
  end

  // Extend returned load data according to the funct3 captured at accept.
  always_comb begin
    case (ld_funct3)
      F3_B:    ld_ext = {{24{ld_data[7]}}, ld_data[7:0]};
      F3_H:    ld_ext = {{16{ld_data[15]}}, ld_data[15:0]};
      F3_BU:   ld_ext = {24'b0, ld_data[7:0]};
      F3_HU:   ld_ext = {16'b0, ld_data[15:0]};
      default: ld_ext = ld_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, drives the MMU request
// interface, waits for completion (with timeout) and returns a response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 7,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_base,
  input  logic [31:0]       req_imm,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic [1:0]        rsp_cause,
  output logic [ADDR_W-1:0] mmu_address,
  output logic [31:0]       mmu_offset,
  output logic [1:0]        mmu_size,
  output logic [31:0]       mmu_dat_in,
  output logic              mmu_mem_op,
  output logic              mmu_start,
  input  logic [31:0]       mmu_dat_out,
  input  logic              mmu_flg_complete
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        ld_f3_q, ld_f3_d;
  logic [ADDR_W-1:0] mmu_address_q, mmu_address_d;
  logic [1:0]        mmu_offset_q, mmu_offset_d;
  logic [1:0]        mmu_size_q, mmu_size_d;
  logic [31:0]       mmu_dat_in_q, mmu_dat_in_d;
  logic              mmu_mem_op_q, mmu_mem_op_d;
  logic              mmu_start_q, mmu_start_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_fault_q, rsp_fault_d;
  logic [1:0]        rsp_cause_q, rsp_cause_d;

  logic [ADDR_W-1:0] al_addr;
  logic [1:0]        al_off;
  logic              al_fault;
  logic [1:0]        al_cause;
  logic [1:0]        al_size;
  logic [31:0]       al_st_data;
  logic [31:0]       al_ld_ext;

  lsu_align #(.ADDR_W(ADDR_W)) u_align (
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_base   (req_base),
    .req_imm    (req_imm),
    .req_wdata  (req_wdata),
    .ld_funct3  (ld_f3_q),
    .ld_data    (mmu_dat_out),
    .word_addr  (al_addr),
    .byte_off   (al_off),
    .fault      (al_fault),
    .cause      (al_cause),
    .size       (al_size),
    .st_data    (al_st_data),
    .ld_ext     (al_ld_ext)
  );

  // Next-state logic for the request FSM, MMU request registers and response registers.
  always_comb begin
    state_d       = state_q;
    req_ready_d   = req_ready_q;
    cnt_d         = cnt_q;
    we_d          = we_q;
    ld_f3_d       = ld_f3_q;
    mmu_address_d = mmu_address_q;
    mmu_offset_d  = mmu_offset_q;
    mmu_size_d    = mmu_size_q;
    mmu_dat_in_d  = mmu_dat_in_q;
    mmu_mem_op_d  = mmu_mem_op_q;
    mmu_start_d   = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_fault_d   = rsp_fault_q;
    rsp_cause_d   = rsp_cause_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_ready_d = 1'b0;
          if (al_fault) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
            rsp_cause_d = al_cause;
            rsp_rdata_d = 32'b0;
          end else begin
            state_d       = ISSUE;
            mmu_start_d   = 1'b1;
            mmu_address_d = al_addr;
            mmu_offset_d  = al_off;
            mmu_size_d    = al_size;
            mmu_dat_in_d  = req_we ? al_st_data : 32'b0;
            mmu_mem_op_d  = req_we;
            we_d          = req_we;
            ld_f3_d       = req_funct3;
            cnt_d         = '0;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (mmu_flg_complete) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_fault_d = 1'b0;
          rsp_cause_d = 2'b0;
          rsp_rdata_d = we_q ? 32'b0 : al_ld_ext;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_fault_d = 1'b1;
          rsp_cause_d = CAUSE_TIMEOUT;
          rsp_rdata_d = 32'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      ld_f3_q       <= 3'b0;
      mmu_address_q <= '0;
      mmu_offset_q  <= 2'b0;
      mmu_size_q    <= 2'b0;
      mmu_dat_in_q  <= 32'b0;
      mmu_mem_op_q  <= 1'b0;
      mmu_start_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'b0;
      rsp_fault_q   <= 1'b0;
      rsp_cause_q   <= 2'b0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      cnt_q         <= cnt_d;
      we_q          <= we_d;
      ld_f3_q       <= ld_f3_d;
      mmu_address_q <= mmu_address_d;
      mmu_offset_q  <= mmu_offset_d;
      mmu_size_q    <= mmu_size_d;
      mmu_dat_in_q  <= mmu_dat_in_d;
      mmu_mem_op_q  <= mmu_mem_op_d;
      mmu_start_q   <= mmu_start_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_fault_q   <= rsp_fault_d;
      rsp_cause_q   <= rsp_cause_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_fault   = rsp_fault_q;
  assign rsp_cause   = rsp_cause_q;
  assign mmu_address = mmu_address_q;
  assign mmu_offset  = {30'b0, mmu_offset_q};
  assign mmu_size    = mmu_size_q;
  assign mmu_dat_in  = mmu_dat_in_q;
  assign mmu_mem_op  = mmu_mem_op_q;
  assign mmu_start   = mmu_start_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: scenario tasks drive requests and
// play the MMU; a response monitor compares against a queue of expected results.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [31:0] req_imm;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [1:0]  rsp_cause;
  logic [6:0]  mmu_address;
  logic [31:0] mmu_offset;
  logic [1:0]  mmu_size;
  logic [31:0] mmu_dat_in;
  logic        mmu_mem_op;
  logic        mmu_start;
  logic [31:0] mmu_dat_out;
  logic        mmu_flg_complete;

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
    logic [1:0]  cause;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  load_store_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_funct3       (req_funct3),
    .req_base         (req_base),
    .req_imm          (req_imm),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .rsp_fault        (rsp_fault),
    .rsp_cause        (rsp_cause),
    .mmu_address      (mmu_address),
    .mmu_offset       (mmu_offset),
    .mmu_size         (mmu_size),
    .mmu_dat_in       (mmu_dat_in),
    .mmu_mem_op       (mmu_mem_op),
    .mmu_start        (mmu_start),
    .mmu_dat_out      (mmu_dat_out),
    .mmu_flg_complete (mmu_flg_complete)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Response monitor: every response pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_rsp: rsp_valid=1 with no response outstanding");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        n_checks++;
        if (rsp_rdata !== e.rdata) begin
          n_fail++;
          $display("[TB] FAIL rsp_rdata: got %h expected %h", rsp_rdata, e.rdata);
        end
        n_checks++;
        if (rsp_fault !== e.fault) begin
          n_fail++;
          $display("[TB] FAIL rsp_fault: got %b expected %b", rsp_fault, e.fault);
        end
        n_checks++;
        if (rsp_cause !== e.cause) begin
          n_fail++;
          $display("[TB] FAIL rsp_cause: got %0d expected %0d", rsp_cause, e.cause);
        end
      end
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Wait (bounded) for req_ready, then present one request for exactly one accept edge.
  // Returns at the falling edge of the cycle after acceptance.
  task automatic issue_req(input logic we, input logic [2:0] f3, input logic [31:0] base,
                           input logic [31:0] imm, input logic [31:0] wdata);
    int k;
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ready_wait: req_ready=%b after %0d cycles, expected 1", req_ready, k);
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_base   = base;
    req_imm    = imm;
    req_wdata  = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b111;
    req_base   = $urandom;
    req_imm    = $urandom;
    req_wdata  = $urandom;
  endtask

  // Act as the MMU: pulse completion 'delay' cycles after the start cycle we are in.
  task automatic mmu_reply(input int delay, input logic [31:0] data);
    repeat (delay) @(negedge clk);
    mmu_flg_complete = 1'b1;
    mmu_dat_out      = data;
    @(negedge clk);
    mmu_flg_complete = 1'b0;
    mmu_dat_out      = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (mmu_start !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mmu_start: got %b expected 0", mmu_start); end
    n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
    n_checks++; if (mmu_address !== 7'h0) begin n_fail++; $display("[TB] FAIL reset_mmu_address: got %h expected 0", mmu_address); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_lw();
    sb_q.push_back('{rdata: 32'hDEADBEEF, fault: 1'b0, cause: 2'd0});
    issue_req(1'b0, 3'b010, 32'h100, 32'h4, 32'h0);
    n_checks++; if (mmu_start !== 1'b1) begin n_fail++; $display("[TB] FAIL lw_start_n1: got %b expected 1", mmu_start); end
    n_checks++; if (mmu_address !== 7'h41) begin n_fail++; $display("[TB] FAIL lw_address: got %h expected 41", mmu_address); end
    n_checks++; if (mmu_offset !== 32'h0) begin n_fail++; $display("[TB] FAIL lw_offset: got %h expected 0", mmu_offset); end
    n_checks++; if (mmu_mem_op !== 1'b0) begin n_fail++; $display("[TB] FAIL lw_mem_op: got %b expected 0", mmu_mem_op); end
    n_checks++; if (mmu_size !== 2'd2) begin n_fail++; $display("[TB] FAIL lw_size: got %0d expected 2", mmu_size); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL lw_ready_busy: got %b expected 0", req_ready); end
    @(negedge clk);
    n_checks++; if (mmu_start !== 1'b0) begin n_fail++; $display("[TB] FAIL lw_start_pulse: got %b expected 0", mmu_start); end
    mmu_reply(2, 32'hDEADBEEF);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL lw_rsp_latency: rsp_valid=%b expected 1", rsp_valid); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL lw_rsp_pulse: got %b expected 0", rsp_valid); end
    n_checks++; if (rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL lw_rsp_hold: got %h expected deadbeef", rsp_rdata); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL lw_ready_after: got %b expected 1", req_ready); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3_t   [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010};
    logic [31:0] imm_t  [6] = '{32'h3, 32'h3, 32'h12, 32'h12, 32'h1EF, 32'hFFFFFFF0};
    logic [31:0] dat_t  [6] = '{32'h80, 32'h80, 32'h8001, 32'h8001, 32'h7F, 32'hCAFEF00D};
    logic [31:0] exp_t_ [6] = '{32'hFFFFFF80, 32'h80, 32'hFFFF8001, 32'h8001, 32'h7F, 32'hCAFEF00D};
    logic [6:0]  adr_t  [6] = '{7'h04, 7'h04, 7'h08, 7'h08, 7'h7F, 7'h00};
    logic [31:0] off_t  [6] = '{32'h3, 32'h3, 32'h2, 32'h2, 32'h3, 32'h0};
    for (int i = 0; i < 6; i++) begin
      sb_q.push_back('{rdata: exp_t_[i], fault: 1'b0, cause: 2'd0});
      issue_req(1'b0, f3_t[i], 32'h10, imm_t[i], 32'h0);
      n_checks++; if (mmu_start !== 1'b1) begin n_fail++; $display("[TB] FAIL ld%0d_start: got %b expected 1", i, mmu_start); end
      n_checks++; if (mmu_address !== adr_t[i]) begin n_fail++; $display("[TB] FAIL ld%0d_address: got %h expected %h", i, mmu_address, adr_t[i]); end
      n_checks++; if (mmu_offset !== off_t[i]) begin n_fail++; $display("[TB] FAIL ld%0d_offset: got %h expected %h", i, mmu_offset, off_t[i]); end
      mmu_reply(1 + (i % 3), dat_t[i]);
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL ld%0d_rsp_latency: rsp_valid=%b expected 1", i, rsp_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_store();
    logic [2:0]  f3_t  [3] = '{3'b001, 3'b000, 3'b010};
    logic [31:0] base_t[3] = '{32'h20, 32'h40, 32'h1F0};
    logic [31:0] imm_t [3] = '{32'h2, 32'h1, 32'hC};
    logic [31:0] wd_t  [3] = '{32'h12345678, 32'hAABBCCDD, 32'h89ABCDEF};
    logic [31:0] din_t [3] = '{32'h00005678, 32'h000000DD, 32'h89ABCDEF};
    logic [1:0]  sz_t  [3] = '{2'd1, 2'd0, 2'd2};
    logic [6:0]  adr_t [3] = '{7'h08, 7'h10, 7'h7F};
    logic [31:0] off_t [3] = '{32'h2, 32'h1, 32'h0};
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{rdata: 32'h0, fault: 1'b0, cause: 2'd0});
      issue_req(1'b1, f3_t[i], base_t[i], imm_t[i], wd_t[i]);
      n_checks++; if (mmu_start !== 1'b1) begin n_fail++; $display("[TB] FAIL st%0d_start: got %b expected 1", i, mmu_start); end
      n_checks++; if (mmu_mem_op !== 1'b1) begin n_fail++; $display("[TB] FAIL st%0d_mem_op: got %b expected 1", i, mmu_mem_op); end
      @(negedge clk);
      n_checks++; if (mmu_dat_in !== din_t[i]) begin n_fail++; $display("[TB] FAIL st%0d_dat_in: got %h expected %h", i, mmu_dat_in, din_t[i]); end
      n_checks++; if (mmu_size !== sz_t[i]) begin n_fail++; $display("[TB] FAIL st%0d_size: got %0d expected %0d", i, mmu_size, sz_t[i]); end
      n_checks++; if (mmu_address !== adr_t[i]) begin n_fail++; $display("[TB] FAIL st%0d_address: got %h expected %h", i, mmu_address, adr_t[i]); end
      n_checks++; if (mmu_offset !== off_t[i]) begin n_fail++; $display("[TB] FAIL st%0d_offset: got %h expected %h", i, mmu_offset, off_t[i]); end
      mmu_reply(1, 32'hFFFFFFFF);
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL st%0d_rsp_latency: rsp_valid=%b expected 1", i, rsp_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_faults();
    logic        we_t  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3_t  [9] = '{3'b010, 3'b010, 3'b011, 3'b100, 3'b001, 3'b010, 3'b110, 3'b000, 3'b001};
    logic [31:0] base_t[9] = '{32'h100, 32'h200, 32'h0, 32'h0, 32'h1F0, 32'h200, 32'h200, 32'h0, 32'h20};
    logic [31:0] imm_t [9] = '{32'h2, 32'h0, 32'h0, 32'h0, 32'hF, 32'h2, 32'h3, 32'hFFFFFFFF, 32'h3};
    logic [1:0]  cau_t [9] = '{2'd0, 2'd1, 2'd3, 2'd3, 2'd0, 2'd0, 2'd3, 2'd1, 2'd0};
    for (int i = 0; i < 9; i++) begin
      sb_q.push_back('{rdata: 32'h0, fault: 1'b1, cause: cau_t[i]});
      issue_req(we_t[i], f3_t[i], base_t[i], imm_t[i], 32'hFFFFFFFF);
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL flt%0d_latency: rsp_valid=%b expected 1", i, rsp_valid); end
      n_checks++; if (mmu_start !== 1'b0) begin n_fail++; $display("[TB] FAIL flt%0d_no_start: got %b expected 0", i, mmu_start); end
      @(negedge clk);
      n_checks++; if (mmu_start !== 1'b0) begin n_fail++; $display("[TB] FAIL flt%0d_no_start_late: got %b expected 0", i, mmu_start); end
    end
    mmu_flg_complete = 1'b1;
    mmu_dat_out      = 32'h55AA55AA;
    @(negedge clk);
    mmu_flg_complete = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL stray_complete_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_timeout();
    int k;
    logic busy_ok;
    sb_q.push_back('{rdata: 32'h0, fault: 1'b1, cause: 2'd2});
    issue_req(1'b0, 3'b010, 32'h0, 32'h8, 32'h0);
    n_checks++; if (mmu_start !== 1'b1) begin n_fail++; $display("[TB] FAIL to_start: got %b expected 1", mmu_start); end
    k = 0;
    busy_ok = 1'b1;
    while (k < 100) begin
      @(negedge clk);
      k++;
      if (rsp_valid === 1'b1) break;
      if (req_ready !== 1'b0) busy_ok = 1'b0;
    end
    n_checks++; if (k != 65) begin n_fail++; $display("[TB] FAIL to_latency: response %0d cycles after start, expected 65", k); end
    n_checks++; if (busy_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL to_ready_low: req_ready rose before timeout response (ok=%b expected 1)", busy_ok); end
    @(negedge clk);
    mmu_flg_complete = 1'b1;
    @(negedge clk);
    mmu_flg_complete = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    issue_req(1'b0, 3'b010, 32'h40, 32'h0, 32'h0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rmid_ready: got %b expected 1", req_ready); end
    n_checks++; if (mmu_address !== 7'h0) begin n_fail++; $display("[TB] FAIL rmid_address: got %h expected 0", mmu_address); end
    n_checks++; if (rsp_fault !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_rsp_fault: got %b expected 0", rsp_fault); end
    n_checks++; if (rsp_cause !== 2'd0) begin n_fail++; $display("[TB] FAIL rmid_rsp_cause: got %0d expected 0", rsp_cause); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    sb_q.push_back('{rdata: 32'h12345678, fault: 1'b0, cause: 2'd0});
    issue_req(1'b0, 3'b010, 32'h1F0, 32'hC, 32'h0);
    n_checks++; if (mmu_start !== 1'b1) begin n_fail++; $display("[TB] FAIL rmid_next_start: got %b expected 1", mmu_start); end
    n_checks++; if (mmu_address !== 7'h7F) begin n_fail++; $display("[TB] FAIL rmid_next_address: got %h expected 7f", mmu_address); end
    mmu_reply(3, 32'h12345678);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL rmid_next_rsp: rsp_valid=%b expected 1", rsp_valid); end
    @(negedge clk);
  endtask

  // Run every scenario in order, then report.
  initial begin
    rst_n            = 1'b0;
    req_valid        = 1'b0;
    req_we           = 1'b0;
    req_funct3       = 3'b0;
    req_base         = 32'h0;
    req_imm          = 32'h0;
    req_wdata        = 32'h0;
    mmu_dat_out      = 32'h0;
    mmu_flg_complete = 1'b0;
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_faults();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL missing_rsp: %0d responses outstanding, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
